// File: rtl/crypto_job_arbiter.sv
// Round-robin arbiter that shares one block-cipher engine among NUM_REQ requesters.
// Latches the winning job, pulses the engine, then returns ciphertext or a timeout error to the owner.
module crypto_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BLOCK_W = 128,
  parameter int TIMEOUT = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_plaintext,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_key,
  output logic [NUM_REQ-1:0]         resp_valid,
  input  logic [NUM_REQ-1:0]         resp_ready,
  output logic [BLOCK_W-1:0]         resp_data,
  output logic                       resp_err,
  output logic                       eng_start,
  output logic [BLOCK_W-1:0]         eng_plaintext,
  output logic [BLOCK_W-1:0]         eng_key,
  input  logic                       eng_done,
  input  logic [BLOCK_W-1:0]         eng_ciphertext,
  output logic                       busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic [1:0]         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   grant_id_q, grant_id_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [BLOCK_W-1:0] pt_q, pt_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic               err_q, err_d;

  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   cand_idx;
  logic [BLOCK_W-1:0] sel_pt;
  logic [BLOCK_W-1:0] sel_key;

  // Walk candidates from rr_ptr upward with explicit wrap so non-power-of-two NUM_REQ stays in range.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
      cand_idx = (cand_idx == LAST_IDX) ? '0 : cand_idx + 1'b1;
    end
  end

  always_comb begin
    sel_pt  = '0;
    sel_key = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_pt  = req_plaintext[i*BLOCK_W +: BLOCK_W];
        sel_key = req_key[i*BLOCK_W +: BLOCK_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    timer_d    = timer_q;
    pt_d       = pt_q;
    key_d      = key_q;
    data_d     = data_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          pt_d       = sel_pt;
          key_d      = sel_key;
          grant_id_d = grant_idx;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion on the final timer cycle still counts as success.
        if (eng_done) begin
          data_d  = eng_ciphertext;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TMR_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready[grant_id_q]) begin
          rr_ptr_d = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      timer_q    <= '0;
      pt_q       <= '0;
      key_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      timer_q    <= timer_d;
      pt_q       <= pt_d;
      key_q      <= key_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign req_ready     = (state_q == IDLE && grant_found) ? (ONE_HOT0 << grant_idx) : '0;
  assign resp_valid    = (state_q == RESP) ? (ONE_HOT0 << grant_id_q) : '0;
  assign resp_data     = data_q;
  assign resp_err      = err_q;
  assign eng_start     = (state_q == ISSUE);
  assign eng_plaintext = pt_q;
  assign eng_key       = key_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_crypto_job_arbiter.sv
// Bench for crypto_job_arbiter: a job-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_crypto_job_arbiter;

  localparam int NUM_REQ = 4;
  localparam int BLOCK_W = 128;
  localparam int TIMEOUT = 32;

  localparam logic [127:0] PT1  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] KEY1 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] CT1  = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
  localparam logic [127:0] CT4  = 128'hCAFEF00DCAFEF00DCAFEF00DCAFEF00D;
  localparam logic [127:0] CT5  = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*BLOCK_W-1:0] req_plaintext = '0;
  logic [NUM_REQ*BLOCK_W-1:0] req_key = '0;
  logic [NUM_REQ-1:0]         resp_valid;
  logic [NUM_REQ-1:0]         resp_ready = '0;
  logic [BLOCK_W-1:0]         resp_data;
  logic                       resp_err;
  logic                       eng_start;
  logic [BLOCK_W-1:0]         eng_plaintext;
  logic [BLOCK_W-1:0]         eng_key;
  logic                       eng_done = 1'b0;
  logic [BLOCK_W-1:0]         eng_ciphertext = '0;
  logic                       busy;

  int total = 0;
  int bad = 0;
  int startCount = 0;
  int startBase = 0;
  int n = 0;
  bit checkEn = 1'b0;
  bit recordGrants = 1'b0;
  int grants[$];

  crypto_job_arbiter #(.NUM_REQ(NUM_REQ), .BLOCK_W(BLOCK_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_plaintext(req_plaintext), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .eng_start(eng_start), .eng_plaintext(eng_plaintext), .eng_key(eng_key),
    .eng_done(eng_done), .eng_ciphertext(eng_ciphertext),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Job-level model: one job in flight, its age since issue, and the response it has earned.
  bit           mActive = 1'b0;
  bit           mHaveResp = 1'b0;
  int           mOwner = 0;
  int           mAge = 0;
  int           mRr = 0;
  logic [127:0] mPt = '0;
  logic [127:0] mKey = '0;
  logic [127:0] mData = '0;
  logic         mErr = 1'b0;

  function automatic int pickGrant(logic [NUM_REQ-1:0] v, int rr);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] expReady();
    int g;
    g = pickGrant(req_valid, mRr);
    if (mActive || g < 0) return '0;
    return NUM_REQ'(1) << g;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mActive <= 1'b0; mHaveResp <= 1'b0; mOwner <= 0; mAge <= 0; mRr <= 0;
      mPt <= '0; mKey <= '0; mData <= '0; mErr <= 1'b0;
    end else if (!mActive) begin
      if (pickGrant(req_valid, mRr) >= 0) begin
        mOwner    <= pickGrant(req_valid, mRr);
        mPt       <= req_plaintext[pickGrant(req_valid, mRr)*BLOCK_W +: BLOCK_W];
        mKey      <= req_key[pickGrant(req_valid, mRr)*BLOCK_W +: BLOCK_W];
        mActive   <= 1'b1;
        mHaveResp <= 1'b0;
        mAge      <= 0;
      end
    end else if (!mHaveResp) begin
      if (mAge >= 1 && eng_done) begin
        mData <= eng_ciphertext; mErr <= 1'b0; mHaveResp <= 1'b1;
      end else if (mAge == TIMEOUT) begin
        mData <= '0; mErr <= 1'b1; mHaveResp <= 1'b1;
      end
      mAge <= mAge + 1;
    end else if (resp_ready[mOwner]) begin
      mActive <= 1'b0;
      mRr     <= (mOwner + 1) % NUM_REQ;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (eng_start) startCount++;
    if (recordGrants && (req_ready & req_valid) != '0)
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) grants.push_back(i);
    if (checkEn) begin
      checkOutput("busy", 128'(busy), 128'(mActive));
      checkOutput("req_ready", 128'(req_ready), 128'(expReady()));
      checkOutput("eng_start", 128'(eng_start), 128'(mActive && !mHaveResp && mAge == 0));
      checkOutput("eng_plaintext", eng_plaintext, mPt);
      checkOutput("eng_key", eng_key, mKey);
      checkOutput("resp_valid", 128'(resp_valid),
                  128'((mActive && mHaveResp) ? (NUM_REQ'(1) << mOwner) : NUM_REQ'(0)));
      checkOutput("resp_data", resp_data, mData);
      checkOutput("resp_err", 128'(resp_err), 128'(mErr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitStart();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!eng_start && k < 100);
    checkOutput("eng_start_seen", 128'(eng_start), 128'(1));
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [NUM_REQ-1:0] ready);
    req_valid  = valid;
    resp_ready = ready;
  endtask

  initial begin
    repeat (3) tick();
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_resp_valid", 128'(resp_valid), 128'(0));
    checkOutput("reset_eng_start", 128'(eng_start), 128'(0));
    checkOutput("reset_eng_plaintext", eng_plaintext, 128'(0));
    checkOutput("reset_req_ready", 128'(req_ready), 128'(0));
    checkEn = 1'b1;
    tick();
    rst = 1'b0;

    $display("[TB] single job");
    req_plaintext[2*BLOCK_W +: BLOCK_W] = PT1;
    req_key[2*BLOCK_W +: BLOCK_W] = KEY1;
    startBase = startCount;
    applyStimulus(4'b0100, 4'b0000);
    waitStart();
    req_valid = '0;
    checkOutput("t1_eng_plaintext", eng_plaintext, PT1);
    checkOutput("t1_eng_key", eng_key, KEY1);
    repeat (5) tick();
    eng_done = 1'b1; eng_ciphertext = CT1;
    tick();
    eng_done = 1'b0;
    checkOutput("t1_resp_valid", 128'(resp_valid), 128'(4'b0100));
    checkOutput("t1_resp_data", resp_data, CT1);
    checkOutput("t1_resp_err", 128'(resp_err), 128'(0));
    checkOutput("t1_start_pulses", 128'(startCount - startBase), 128'(1));
    resp_ready = 4'b0100;
    tick();
    resp_ready = '0;
    req_valid = 4'b1111;
    #1;
    checkOutput("t1_next_grant_3", 128'(req_ready), 128'(4'b1000));
    req_valid = '0;

    $display("[TB] round robin");
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    grants.delete();
    recordGrants = 1'b1;
    applyStimulus(4'b1111, 4'b1111);
    for (int j = 0; j < 8; j++) begin
      waitStart();
      if (j == 7) req_valid = '0;
      tick();
      eng_done = 1'b1; eng_ciphertext = 128'(32'hC0DE0000 + j);
      tick();
      eng_done = 1'b0;
    end
    repeat (3) tick();
    recordGrants = 1'b0;
    checkOutput("t2_grant_count", 128'(grants.size()), 128'(8));
    for (int j = 0; j < 8 && j < grants.size(); j++)
      checkOutput("t2_grant_order", 128'(grants[j]), 128'(j % 4));

    $display("[TB] timeout");
    applyStimulus(4'b0001, 4'b1111);
    waitStart();
    req_valid = '0;
    n = 0;
    while (resp_valid == '0 && n < 60) begin
      tick();
      n++;
    end
    checkOutput("t3_timeout_latency", 128'(n), 128'(33));
    checkOutput("t3_resp_valid", 128'(resp_valid), 128'(4'b0001));
    checkOutput("t3_resp_err", 128'(resp_err), 128'(1));
    checkOutput("t3_resp_data", resp_data, 128'(0));
    tick();
    eng_done = 1'b1; eng_ciphertext = '1;
    tick();
    eng_done = 1'b0;
    tick();
    checkOutput("t3_stray_busy", 128'(busy), 128'(0));
    checkOutput("t3_stray_data", resp_data, 128'(0));
    checkOutput("t3_stray_err", 128'(resp_err), 128'(1));

    $display("[TB] backpressure");
    applyStimulus(4'b0011, 4'b1101);
    waitStart();
    tick();
    eng_done = 1'b1; eng_ciphertext = CT4;
    tick();
    eng_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checkOutput("t4_hold_valid", 128'(resp_valid), 128'(4'b0010));
      checkOutput("t4_hold_data", resp_data, CT4);
      checkOutput("t4_no_ready", 128'(req_ready), 128'(0));
      tick();
    end
    resp_ready = 4'b1111;
    tick();
    checkOutput("t4_after_release", 128'(req_ready), 128'(4'b0001));
    req_valid = '0;

    $display("[TB] done on timeout cycle");
    applyStimulus(4'b0100, 4'b1111);
    waitStart();
    req_valid = '0;
    repeat (TIMEOUT) tick();
    eng_done = 1'b1; eng_ciphertext = CT5;
    tick();
    eng_done = 1'b0;
    checkOutput("t5_resp_valid", 128'(resp_valid), 128'(4'b0100));
    checkOutput("t5_resp_err", 128'(resp_err), 128'(0));
    checkOutput("t5_resp_data", resp_data, CT5);
    tick();

    $display("[TB] reset mid-wait");
    applyStimulus(4'b1000, 4'b1111);
    waitStart();
    req_valid = '0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_busy", 128'(busy), 128'(0));
    checkOutput("t6_eng_start", 128'(eng_start), 128'(0));
    checkOutput("t6_eng_plaintext", eng_plaintext, 128'(0));
    checkOutput("t6_eng_key", eng_key, 128'(0));
    checkOutput("t6_resp_valid", 128'(resp_valid), 128'(0));
    checkOutput("t6_resp_data", resp_data, 128'(0));
    checkOutput("t6_resp_err", 128'(resp_err), 128'(0));
    checkOutput("t6_req_ready", 128'(req_ready), 128'(0));
    tick();
    rst = 1'b0;
    req_valid = 4'b1010;
    #1;
    checkOutput("t6_grant_after_reset", 128'(req_ready), 128'(4'b0010));
    waitStart();
    req_valid = '0;
    tick();
    eng_done = 1'b1; eng_ciphertext = CT1;
    tick();
    eng_done = 1'b0;
    repeat (3) tick();

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
